// File: rtl/ps2_mouse_device_if.sv
// Movement-report handshake and host-command status between the caller and
// the PS/2 mouse emulator.
interface ps2_mouse_device_if;
  logic [8:0] x_move;
  logic [8:0] y_move;
  logic [2:0] btn;
  logic       mv_valid;
  logic       mv_ready;
  logic       streaming;
  logic [7:0] cmd;
  logic       cmd_tick;

  modport master (output x_move, y_move, btn, mv_valid,
                  input  mv_ready, streaming, cmd, cmd_tick);
  modport slave  (input  x_move, y_move, btn, mv_valid,
                  output mv_ready, streaming, cmd, cmd_tick);
endinterface

// File: rtl/ps2_mouse_device.sv
// PS/2 mouse device-side emulator: owns ps2c, receives host commands, answers
// with ack/response bytes and serialises 3-byte movement packets.
//
// state     | meaning
// S_IDLE    | lines released, waiting for host inhibit or a queued byte
// S_INHIBIT | host holding ps2c low, measuring the low time
// S_RX      | clocking in d0..d7, parity, stop from the host
// S_RX_ACK  | 11th pulse with ps2d held low as acknowledge
// S_TX      | clocking out start, d0..d7, parity, stop
// S_GAP     | idle spacing after a frame
module ps2_mouse_device #(
  parameter int HALF_PERIOD = 2000,
  parameter int INHIBIT_MIN = 5000,
  parameter int GAP         = 4000
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire               ps2c,
  inout  wire               ps2d,
  ps2_mouse_device_if.slave mv
);
  localparam int MAXP = (HALF_PERIOD > INHIBIT_MIN)
                        ? ((HALF_PERIOD > GAP) ? HALF_PERIOD : GAP)
                        : ((INHIBIT_MIN > GAP) ? INHIBIT_MIN : GAP);
  localparam int TW = $clog2(MAXP + 1);
  localparam logic [TW-1:0] HP_LD  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] INH_LD = TW'(INHIBIT_MIN - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RX, S_RX_ACK, S_TX, S_GAP} state_t;

  state_t        state, state_nx;
  logic          c_meta, c_s, d_meta, d_s;
  logic [TW-1:0] timer;
  logic          hi;
  logic [3:0]    pulse;
  logic [10:0]   tx_sh;
  logic [9:0]    rx_sh;
  logic [7:0]    buf0, buf1, buf2;
  logic [1:0]    count;
  logic          streaming_r, cmd_tick_r;
  logic [7:0]    cmd_r;
  logic          c_low, d_low, mv_ready_c;
  logic          tc, rx_ok;

  assign tc    = (timer == '0);
  assign rx_ok = (^rx_sh[8:0]) & rx_sh[9];

  assign ps2c = c_low ? 1'b0 : 1'bz;
  assign ps2d = d_low ? 1'b0 : 1'bz;

  assign mv.mv_ready  = mv_ready_c;
  assign mv.streaming = streaming_r;
  assign mv.cmd       = cmd_r;
  assign mv.cmd_tick  = cmd_tick_r;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (!c_s) state_nx = S_INHIBIT;
                 else if (count != 2'd0) state_nx = S_TX;
      S_INHIBIT: if (c_s) state_nx = (tc && !d_s) ? S_RX : S_IDLE;
      S_RX:      if (tc && hi && pulse == 4'd9) state_nx = S_RX_ACK;
      S_RX_ACK:  if (tc && hi) state_nx = S_GAP;
      S_TX: begin
        if (tc) begin
          if (hi) begin
            if (!c_s) state_nx = S_INHIBIT;
          end else if (pulse == 4'd10) begin
            state_nx = S_GAP;
          end
        end
      end
      S_GAP:     if (tc) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mv_ready_c = streaming_r & (state == S_IDLE) & (count == 2'd0) & c_s;
    c_low      = (state == S_RX || state == S_RX_ACK || state == S_TX) && !hi;
    d_low      = (state == S_RX_ACK) || (state == S_TX && !tx_sh[0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_meta <= 1'b1; c_s <= 1'b1; d_meta <= 1'b1; d_s <= 1'b1;
      timer <= '0; hi <= 1'b1; pulse <= '0;
      tx_sh <= '1; rx_sh <= '0;
      buf0 <= '0; buf1 <= '0; buf2 <= '0; count <= '0;
      streaming_r <= 1'b0; cmd_r <= '0; cmd_tick_r <= 1'b0;
    end else begin
      c_meta <= ps2c; c_s <= c_meta;
      d_meta <= ps2d; d_s <= d_meta;
      cmd_tick_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!c_s) begin
            timer <= INH_LD;
          end else if (count != 2'd0) begin
            tx_sh <= {1'b1, ~^buf0, buf0, 1'b0};
            timer <= HP_LD; hi <= 1'b1; pulse <= '0;
          end else if (mv.mv_valid && mv_ready_c) begin
            buf0  <= {2'b00, mv.y_move[8], mv.x_move[8], 1'b1, mv.btn};
            buf1  <= mv.x_move[7:0];
            buf2  <= mv.y_move[7:0];
            count <= 2'd3;
          end
        end
        S_INHIBIT: begin
          if (c_s) begin
            if (tc && !d_s) begin
              count <= '0; timer <= HP_LD; hi <= 1'b0; pulse <= '0;
            end
          end else if (!tc) begin
            timer <= timer - TW'(1);
          end
        end
        S_RX: begin
          if (!tc) timer <= timer - TW'(1);
          else begin
            timer <= HP_LD;
            if (!hi) begin
              rx_sh <= {d_s, rx_sh[9:1]};
              hi    <= 1'b1;
            end else begin
              hi    <= 1'b0;
              pulse <= pulse + 4'd1;
            end
          end
        end
        S_RX_ACK: begin
          if (!tc) timer <= timer - TW'(1);
          else if (!hi) begin
            hi <= 1'b1; timer <= HP_LD;
          end else begin
            // Any queued bytes are replaced by the response to this command.
            timer <= GAP_LD;
            count <= 2'd1;
            if (!rx_ok) begin
              buf0 <= 8'hFE;
            end else begin
              buf0 <= 8'hFA; cmd_r <= rx_sh[7:0]; cmd_tick_r <= 1'b1;
              case (rx_sh[7:0])
                8'hF4: streaming_r <= 1'b1;
                8'hF5: streaming_r <= 1'b0;
                8'hFF: begin
                  buf1 <= 8'hAA; buf2 <= 8'h00; count <= 2'd3; streaming_r <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
        S_TX: begin
          if (!tc) timer <= timer - TW'(1);
          else if (hi) begin
            if (!c_s) timer <= INH_LD;
            else begin
              hi <= 1'b0; timer <= HP_LD;
            end
          end else if (pulse == 4'd10) begin
            buf0 <= buf1; buf1 <= buf2; count <= count - 2'd1; timer <= GAP_LD;
          end else begin
            pulse <= pulse + 4'd1; hi <= 1'b1; timer <= HP_LD;
            tx_sh <= {1'b1, tx_sh[10:1]};
          end
        end
        S_GAP: if (!tc) timer <= timer - TW'(1);
        default: ;
      endcase
    end
  end
endmodule
